// File: rtl/vram_fill.sv
// Rectangle fill engine for the Specialist VRAM window (0x9000-0xBFFF), one write per clock, yielding to CPU writes.
// Optional VRAM_FILL_PATTERN_EN inverts the pixel byte on odd rows for stripe/dither fills.
module vram_fill (
    input  logic        clk_sys_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [5:0]  col_start_i,
    input  logic [5:0]  col_end_i,
    input  logic [7:0]  row_start_i,
    input  logic [7:0]  row_end_i,
    input  logic [7:0]  fill_data_i,
    input  logic [7:0]  fill_color_i,
    input  logic        cpu_we_i,
    output logic [15:0] addr_o,
    output logic [7:0]  dout_o,
    output logic [7:0]  color_o,
    output logic        we_o,
    output logic        busy_o,
    output logic        done_o
);

`ifdef VRAM_FILL_PATTERN_EN
    localparam logic PAT_EN = 1'b1;
`else
    localparam logic PAT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t      state_q;
    logic [5:0]  col_q, col_end_q;
    logic [7:0]  row_q, row_start_q, row_end_q, data_q;
    logic [15:0] addr_q;
    logic [7:0]  dout_q, color_q;
    logic        we_pending_q, busy_q, done_q;

    logic [5:0]  col_d, col_end_clamp;
    logic [7:0]  row_d;
    logic        empty, advance, last;

    function automatic logic [15:0] cell_addr(input logic [5:0] c, input logic [7:0] r);
        return 16'h9000 + {2'b00, c, r};
    endfunction

    function automatic logic [7:0] pix(input logic [7:0] d, input logic [7:0] r);
        return d ^ {8{PAT_EN & r[0]}};
    endfunction

    always_comb begin
        col_end_clamp = (col_end_i > 6'd47) ? 6'd47 : col_end_i;
        empty         = (col_start_i > col_end_clamp) || (row_start_i > row_end_i);
        advance       = we_pending_q & ~cpu_we_i;
        last          = (col_q == col_end_q) && (row_q == row_end_q);
        // Row is the inner loop so each column is a run of sequential addresses.
        if (row_q == row_end_q) begin
            row_d = row_start_q;
            col_d = col_q + 6'd1;
        end else begin
            row_d = row_q + 8'd1;
            col_d = col_q;
        end
    end

    always_ff @(posedge clk_sys_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            col_end_q    <= '0;
            row_start_q  <= '0;
            row_end_q    <= '0;
            data_q       <= '0;
            addr_q       <= '0;
            dout_q       <= '0;
            color_q      <= '0;
            we_pending_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                // DONE behaves as idle so a new fill can start in the done cycle.
                IDLE, DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                    if (start_i) begin
                        col_end_q   <= col_end_clamp;
                        row_start_q <= row_start_i;
                        row_end_q   <= row_end_i;
                        data_q      <= fill_data_i;
                        color_q     <= fill_color_i;
                        col_q       <= col_start_i;
                        row_q       <= row_start_i;
                        if (empty) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q      <= WRITE;
                            busy_q       <= 1'b1;
                            we_pending_q <= 1'b1;
                            addr_q       <= cell_addr(col_start_i, row_start_i);
                            dout_q       <= pix(fill_data_i, row_start_i);
                        end
                    end
                end
                WRITE: begin
                    if (abort_i) begin
                        state_q      <= IDLE;
                        we_pending_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end else if (advance) begin
                        if (last) begin
                            state_q      <= DONE;
                            done_q       <= 1'b1;
                            we_pending_q <= 1'b0;
                            busy_q       <= 1'b0;
                        end else begin
                            col_q  <= col_d;
                            row_q  <= row_d;
                            addr_q <= cell_addr(col_d, row_d);
                            dout_q <= pix(data_q, row_d);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign we_o    = we_pending_q & ~cpu_we_i;
    assign addr_o  = addr_q;
    assign dout_o  = dout_q;
    assign color_o = color_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_vram_fill.sv
// Directed bench for vram_fill: a negedge monitor logs writes/done/busy, scenario tasks check the log.
module tb_vram_fill;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, abort, cpu_we;
    logic [5:0]  cs, ce;
    logic [7:0]  rs, re, fd, fc;
    logic [15:0] addr;
    logic [7:0]  dout, color;
    logic        we, busy, done;

    vram_fill dut (
        .clk_sys_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
        .col_start_i(cs), .col_end_i(ce), .row_start_i(rs), .row_end_i(re),
        .fill_data_i(fd), .fill_color_i(fc), .cpu_we_i(cpu_we),
        .addr_o(addr), .dout_o(dout), .color_o(color),
        .we_o(we), .busy_o(busy), .done_o(done)
    );

`ifdef VRAM_FILL_PATTERN_EN
    localparam logic PAT = 1'b1;
`else
    localparam logic PAT = 1'b0;
`endif

    int tests = 0, fails = 0;
    int cyc = 0, ndone = 0, nbusy = 0, done_cyc = 0;
    logic [15:0] wa[$];
    logic [7:0]  wd[$];
    logic [7:0]  wc[$];
    int          wcyc[$];

    always @(negedge clk) begin
        cyc++;
        if (we) begin
            wa.push_back(addr); wd.push_back(dout); wc.push_back(color); wcyc.push_back(cyc);
        end
        if (done) begin ndone++; done_cyc = cyc; end
        if (busy) nbusy++;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_log();
        wa.delete(); wd.delete(); wc.delete(); wcyc.delete();
        ndone = 0; nbusy = 0;
    endtask

    // Start high for one cycle; n0 is the cycle whose closing edge samples it.
    task automatic launch(input logic [5:0] c0, input logic [5:0] c1, input logic [7:0] r0,
                          input logic [7:0] r1, input logic [7:0] d, input logic [7:0] c, output int n0);
        cs = c0; ce = c1; rs = r0; re = r1; fd = d; fc = c;
        start = 1'b1; n0 = cyc + 1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (ndone == 0 && k < budget) begin tick(); k++; end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 0; abort = 0; cpu_we = 0;
        cs = 0; ce = 0; rs = 0; re = 0; fd = 0; fc = 0;
        tick(); tick();
        tests++; if (addr !== 16'h0)  begin fails++; $display("FAIL reset_addr got %h exp 0000", addr); end
        tests++; if (dout !== 8'h0)   begin fails++; $display("FAIL reset_dout got %h exp 00", dout); end
        tests++; if (color !== 8'h0)  begin fails++; $display("FAIL reset_color got %h exp 00", color); end
        tests++; if (we !== 1'b0)     begin fails++; $display("FAIL reset_we got %b exp 0", we); end
        tests++; if (busy !== 1'b0)   begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests++; if (done !== 1'b0)   begin fails++; $display("FAIL reset_done got %b exp 0", done); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int n0;
        clear_log();
        launch(6'd5, 6'd5, 8'd10, 8'd10, 8'hA5, 8'h70, n0);
        wait_done(20);
        tests++; if (wa.size() !== 1)       begin fails++; $display("FAIL single_count got %0d exp 1", wa.size()); end
        tests++; if (wa[0] !== 16'h950A)    begin fails++; $display("FAIL single_addr got %h exp 950A", wa[0]); end
        tests++; if (wd[0] !== 8'hA5)       begin fails++; $display("FAIL single_dout got %h exp A5", wd[0]); end
        tests++; if (wc[0] !== 8'h70)       begin fails++; $display("FAIL single_color got %h exp 70", wc[0]); end
        tests++; if (wcyc[0] !== n0 + 1)    begin fails++; $display("FAIL single_wcyc got %0d exp %0d", wcyc[0], n0 + 1); end
        tests++; if (done_cyc !== n0 + 2)   begin fails++; $display("FAIL single_done got %0d exp %0d", done_cyc, n0 + 2); end
        tests++; if (nbusy !== 1)           begin fails++; $display("FAIL single_busy got %0d exp 1", nbusy); end
        tests++; if (ndone !== 1)           begin fails++; $display("FAIL single_ndone got %0d exp 1", ndone); end
    endtask

    task automatic test_back_to_back();
        int n0, n1, k;
        clear_log();
        launch(6'd1, 6'd1, 8'd2, 8'd2, 8'h11, 8'h22, n0);
        tick();
        // This cycle is n0+2, the done cycle of the first fill.
        launch(6'd3, 6'd3, 8'd4, 8'd4, 8'h33, 8'h44, n1);
        k = 0;
        while (ndone < 2 && k < 20) begin tick(); k++; end
        tests++; if (n1 !== n0 + 2)         begin fails++; $display("FAIL b2b_align got %0d exp %0d", n1, n0 + 2); end
        tests++; if (wa.size() !== 2)       begin fails++; $display("FAIL b2b_count got %0d exp 2", wa.size()); end
        tests++; if (wa[1] !== 16'h9304)    begin fails++; $display("FAIL b2b_addr got %h exp 9304", wa[1]); end
        tests++; if (wcyc[1] !== n1 + 1)    begin fails++; $display("FAIL b2b_wcyc got %0d exp %0d", wcyc[1], n1 + 1); end
        tests++; if (done_cyc !== n1 + 2)   begin fails++; $display("FAIL b2b_done got %0d exp %0d", done_cyc, n1 + 2); end
    endtask

    task automatic test_full();
        int n0, bad;
        clear_log();
        launch(6'd0, 6'd47, 8'd0, 8'd255, 8'h3C, 8'h07, n0);
        wait_done(13000);
        bad = 0;
        for (int i = 1; i < wa.size(); i++) if (wa[i] !== wa[i-1] + 16'd1) bad++;
        tests++; if (wa.size() !== 12288)   begin fails++; $display("FAIL full_count got %0d exp 12288", wa.size()); end
        tests++; if (wa[0] !== 16'h9000)    begin fails++; $display("FAIL full_first got %h exp 9000", wa[0]); end
        tests++; if (wa[wa.size()-1] !== 16'hBFFF) begin fails++; $display("FAIL full_last got %h exp BFFF", wa[wa.size()-1]); end
        tests++; if (bad !== 0)             begin fails++; $display("FAIL full_seq got %0d breaks exp 0", bad); end
        tests++; if (done_cyc !== n0 + 12289) begin fails++; $display("FAIL full_done got %0d exp %0d", done_cyc, n0 + 12289); end
    endtask

    task automatic test_stall();
        int n0, idx, bad;
        logic [15:0] e;
        clear_log();
        launch(6'd2, 6'd5, 8'd100, 8'd103, 8'h55, 8'h1E, n0);
        tick();
        // start while busy must be ignored
        cs = 6'd40; ce = 6'd40; rs = 8'd0; re = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        cpu_we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (we !== 1'b0)       begin fails++; $display("FAIL stall_we[%0d] got %b exp 0", i, we); end
            tests++; if (addr !== 16'h9364) begin fails++; $display("FAIL stall_addr[%0d] got %h exp 9364", i, addr); end
            tick();
        end
        cpu_we = 1'b0;
        wait_done(40);
        idx = 0; bad = 0;
        for (int c = 2; c <= 5; c++)
            for (int r = 100; r <= 103; r++) begin
                e = 16'h9000 + 16'(c * 256 + r);
                if (idx >= wa.size() || wa[idx] !== e) bad++;
                idx++;
            end
        tests++; if (wa.size() !== 16)      begin fails++; $display("FAIL stall_count got %0d exp 16", wa.size()); end
        tests++; if (bad !== 0)             begin fails++; $display("FAIL stall_seq got %0d bad cells exp 0", bad); end
        tests++; if (wcyc[4] !== n0 + 8)    begin fails++; $display("FAIL stall_w5cyc got %0d exp %0d", wcyc[4], n0 + 8); end
        tests++; if (done_cyc !== n0 + 20)  begin fails++; $display("FAIL stall_done got %0d exp %0d", done_cyc, n0 + 20); end
    endtask

    task automatic test_clamp_empty();
        int n0;
        clear_log();
        launch(6'd46, 6'd63, 8'd250, 8'd255, 8'hFF, 8'h01, n0);
        wait_done(40);
        tests++; if (wa.size() !== 12)      begin fails++; $display("FAIL clamp_count got %0d exp 12", wa.size()); end
        tests++; if (wa[0] !== 16'hBEFA)    begin fails++; $display("FAIL clamp_first got %h exp BEFA", wa[0]); end
        tests++; if (wa[wa.size()-1] !== 16'hBFFF) begin fails++; $display("FAIL clamp_last got %h exp BFFF", wa[wa.size()-1]); end
        tests++; if (done_cyc !== n0 + 13)  begin fails++; $display("FAIL clamp_done got %0d exp %0d", done_cyc, n0 + 13); end
        tick();
        clear_log();
        launch(6'd0, 6'd3, 8'd9, 8'd8, 8'hFF, 8'h01, n0);
        wait_done(10);
        tests++; if (wa.size() !== 0)       begin fails++; $display("FAIL empty_count got %0d exp 0", wa.size()); end
        tests++; if (done_cyc !== n0 + 1)   begin fails++; $display("FAIL empty_done got %0d exp %0d", done_cyc, n0 + 1); end
        tests++; if (nbusy !== 0)           begin fails++; $display("FAIL empty_busy got %0d exp 0", nbusy); end
    endtask

    task automatic test_abort();
        int n0;
        clear_log();
        launch(6'd0, 6'd1, 8'd0, 8'd7, 8'h99, 8'h02, n0);
        for (int i = 0; i < 7; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tests++; if (busy !== 1'b0)         begin fails++; $display("FAIL abort_busy got %b exp 0", busy); end
        tests++; if (we !== 1'b0)           begin fails++; $display("FAIL abort_we got %b exp 0", we); end
        for (int i = 0; i < 5; i++) tick();
        tests++; if (wa.size() !== 8)       begin fails++; $display("FAIL abort_count got %0d exp 8", wa.size()); end
        tests++; if (ndone !== 0)           begin fails++; $display("FAIL abort_ndone got %0d exp 0", ndone); end
        // abort together with start in IDLE is ignored
        clear_log();
        abort = 1'b1;
        launch(6'd0, 6'd0, 8'd0, 8'd1, 8'h99, 8'h02, n0);
        abort = 1'b0;
        wait_done(20);
        tests++; if (wa.size() !== 2)       begin fails++; $display("FAIL abort_idle_count got %0d exp 2", wa.size()); end
        tests++; if (ndone !== 1)           begin fails++; $display("FAIL abort_idle_done got %0d exp 1", ndone); end
    endtask

    task automatic test_reset_mid();
        int n0;
        clear_log();
        launch(6'd0, 6'd3, 8'd0, 8'd255, 8'h77, 8'h03, n0);
        tick(); tick(); tick();
        reset = 1'b1;
        #1;
        tests++; if (we !== 1'b0)           begin fails++; $display("FAIL rstmid_we got %b exp 0", we); end
        tests++; if (busy !== 1'b0)         begin fails++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        tests++; if (addr !== 16'h0)        begin fails++; $display("FAIL rstmid_addr got %h exp 0000", addr); end
        tick();
        reset = 1'b0;
        tick();
        clear_log();
        launch(6'd7, 6'd7, 8'd7, 8'd7, 8'h12, 8'h34, n0);
        wait_done(20);
        tests++; if (wa.size() !== 1)       begin fails++; $display("FAIL rstmid_count got %0d exp 1", wa.size()); end
        tests++; if (wa[0] !== 16'h9707)    begin fails++; $display("FAIL rstmid_addr2 got %h exp 9707", wa[0]); end
        tests++; if (done_cyc !== n0 + 2)   begin fails++; $display("FAIL rstmid_done got %0d exp %0d", done_cyc, n0 + 2); end
    endtask

    task automatic test_pattern();
        int n0;
        logic [7:0] e;
        clear_log();
        launch(6'd0, 6'd0, 8'd0, 8'd3, 8'h0F, 8'h05, n0);
        wait_done(20);
        tests++; if (wa.size() !== 4)       begin fails++; $display("FAIL pat_count got %0d exp 4", wa.size()); end
        for (int r = 0; r < 4; r++) begin
            e = (PAT && (r % 2 == 1)) ? 8'hF0 : 8'h0F;
            tests++; if (wd[r] !== e)       begin fails++; $display("FAIL pat_dout[%0d] got %h exp %h", r, wd[r], e); end
            tests++; if (wc[r] !== 8'h05)   begin fails++; $display("FAIL pat_color[%0d] got %h exp 05", r, wc[r]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_stall();
        test_clamp_empty();
        test_abort();
        test_reset_mid();
        test_pattern();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vram_fill.md
# vram_fill

Hardware rectangle fill engine that writes pixel bytes and colour attributes into the Specialist video RAM through the same CPU-bus write port the video generator's VRAM uses (address window 0x9000–0xBFFF, pixel byte plus colour byte per write). The video scan logic reads VRAM; this block is the writer that drives it. It clears or fills a column/row rectangle at one write per clk_sys, and yields to CPU writes cycle-by-cycle. Typical uses are boot-time screen clear and monitor-ROM accelerated CLS.

## Interface
- No parameters.
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request; sampled only in IDLE
- abort  in  1  terminate the current fill
- col_start, col_end  in  6  byte-column bounds, inclusive; valid range 0–47
- row_start, row_end  in  8  scanline bounds, inclusive; valid range 0–255
- fill_data  in  8  pixel byte to write
- fill_color  in  8  colour attribute byte to write
- cpu_we  in  1  CPU VRAM write in this cycle; it has priority
- addr  out  16  CPU-space write address
- dout  out  8  pixel byte
- color  out  8  colour byte
- we  out  1  write strobe, combinational: we_pending & ~cpu_we
- busy  out  1  high in WRITE
- done  out  1  one-cycle pulse on normal completion

## Operation
- States: IDLE, WRITE, DONE.
- IDLE -> WRITE: on start.
  - Latch the bounds and data, clamping col_end to 47 if greater.
  - Set cursor col = col_start, row = row_start.
- IDLE -> DONE: on start when the rectangle is empty (col_start > clamped col_end, or row_start > row_end). No writes are issued.
- Address mapping: addr = 16'h9000 + {col[5:0], row[7:0]}, so VRAM word = {col,row}.
- Scan order:
  - Row is the inner loop: the cursor steps row_start..row_end, then col+1, and row reloads row_start.
  - Successive addresses are therefore sequential within a column.
- Advance rule:
  - The cursor advances only on an edge where we_pending=1 and cpu_we=0.
  - When cpu_we=1 the same cell is held and retried.
- After the last cell is written (col = col_end, row = row_end, not stalled), go WRITE -> DONE.
- DONE: done=1 for one cycle, then IDLE.
- abort sampled high in WRITE: next state is IDLE with we_pending=0 and no done pulse. A write presented in the abort cycle still completes if cpu_we=0.
- start while busy: ignored. start and abort together in IDLE: abort is ignored.
- Total writes = (col_end - col_start + 1) × (row_end - row_start + 1), after clamping.

## Timing
- Reset values: state IDLE, addr 0, dout 0, color 0, we_pending 0, we 0, busy 0, done 0, cursor 0.
- Reset takes effect immediately mid-fill; no write completes after reset asserts.
- addr, dout, color, we_pending, busy and done are registered.
- start high at edge N:
  - busy=1 and the first write is presented during cycle N+1.
  - Unstalled, the k-th write is presented in cycle N+k.
- Last write in cycle M: done=1 and busy=0 in cycle M+1; start is accepted again from M+1.
- Empty rectangle: done=1 in cycle N+1, busy stays 0.
- Each cpu_we cycle adds exactly one cycle to the fill. addr, dout and color are held stable while stalled.

## Configuration
- VRAM_FILL_PATTERN_EN defined: dout = fill_data ^ {8{row[0]}}, so odd rows are inverted for dither or stripe fills. color is unaffected.
- VRAM_FILL_PATTERN_EN undefined: dout = fill_data on every row.

## Test plan
- 1×1 fill: col 5, row 10, data 0xA5, color 0x70, start at N. Expect:
  - one write in N+1 with addr=0x950A, dout=0xA5, color=0x70;
  - done in N+2;
  - busy high for exactly 1 cycle.
- Full screen: cols 0–47, rows 0–255. Expect:
  - 12288 writes, addresses 0x9000..0xBFFF strictly ascending;
  - done 12289 cycles after start.
- Stall: 4×4 fill with cpu_we held high for 3 cycles mid-fill. Expect:
  - we=0 during those cycles, with addr held;
  - 16 writes total, no cell skipped or repeated;
  - done delayed by 3 cycles.
- Clamp and empty: col_end=63 fills up to col 47 only (last addr 0xBFxx). row_start=9, row_end=8 gives done in N+1 with zero writes.
- Abort and reset: abort after 7 writes gives 8 writes maximum, no done, busy=0 next cycle. Asynchronous reset mid-fill drops we and busy immediately. A subsequent start works normally.
- Pattern: with VRAM_FILL_PATTERN_EN, rows 0–3 and data 0x0F give dout 0x0F, 0xF0, 0x0F, 0xF0. Without the macro, all four rows give 0x0F.
